// File: rtl/scan_enc_pkg.sv
// scan_enc_pkg: shared types and helpers for priority_scan_encoder.
// Holds the FSM state encoding and the index-width calculation so the
// top and any checker bound to it agree on both.
package scan_enc_pkg;

  // FSM state encoding; the numeric values are visible on state_dbg.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMPTY = 2'd2
  } scan_state_e;

  // Index width: enough bits to name every bit position, never below 1.
  function automatic int calc_idx_w(input int width);
    if (width <= 1) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/first_one_finder.sv
// first_one_finder: combinational lowest-set-bit locator.
// Returns the index of the lowest set bit of vec_i (0 when none is set)
// and a one-hot mask selecting that bit (all zero when none is set).
module first_one_finder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] onehot_o
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + WIDTH'(1));

endmodule

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: captures one status vector and streams the index
// of every bit equal to ENCODED_VAL, one index per out_valid/out_ready
// handshake, lowest-first (MSB_FIRST=0) or highest-first (MSB_FIRST=1).
//
// Handshake rules: a vector is taken on a clock edge where in_valid and
// in_ready are both high; an index is consumed on an edge where out_valid
// and out_ready are both high. While out_valid is high and out_ready is
// low, encoded_out/out_last/none_found hold their values. flush overrides
// both handshakes and nothing is taken or consumed on that edge.
//
// Optional feature: define SCAN_ENC_MATCH_COUNT_EN to add the match_count
// output (popcount of the match mask, captured at accept).
module priority_scan_encoder
  import scan_enc_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int ENCODED_VAL = 0,
  parameter int MSB_FIRST   = 0,
  localparam int IDX_W      = calc_idx_w(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       encoded_out,
  output logic                   out_last,
  output logic                   none_found,
  output logic                   busy,
`ifdef SCAN_ENC_MATCH_COUNT_EN
  output logic [$clog2(INPUT_WIDTH+1)-1:0] match_count,
`endif
  output logic [1:0]             state_dbg
);

  scan_state_e            state_q, state_d;
  logic [INPUT_WIDTH-1:0] pending_q, pending_d;
  logic [INPUT_WIDTH-1:0] match_mask;
  logic [INPUT_WIDTH-1:0] scan_vec;
  logic [INPUT_WIDTH-1:0] ff_onehot;
  logic [INPUT_WIDTH-1:0] clr_mask;
  logic [IDX_W-1:0]       ff_idx;
  logic [IDX_W-1:0]       cur_idx;
  logic                   single_left;

  // Bits that count as a match become ones in the mask.
  assign match_mask = (ENCODED_VAL != 0) ? data_in : ~data_in;

  // Highest-first order reuses the lowest-first finder on a bit-reversed view.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      for (genvar i = 0; i < INPUT_WIDTH; i++) begin : g_rev
        assign scan_vec[i] = pending_q[INPUT_WIDTH-1-i];
        assign clr_mask[i] = ff_onehot[INPUT_WIDTH-1-i];
      end
      assign cur_idx = IDX_W'(INPUT_WIDTH - 1) - ff_idx;
    end else begin : g_lsb_first
      assign scan_vec = pending_q;
      assign clr_mask = ff_onehot;
      assign cur_idx  = ff_idx;
    end
  endgenerate

  first_one_finder #(
    .WIDTH (INPUT_WIDTH),
    .IDX_W (IDX_W)
  ) u_finder (
    .vec_i    (scan_vec),
    .idx_o    (ff_idx),
    .onehot_o (ff_onehot)
  );

  // Exactly one match left when clearing the lowest set bit empties the mask.
  assign single_left = ((pending_q & (pending_q - INPUT_WIDTH'(1))) == '0);

  // Next-state logic: flush first, then the handshake of the current state.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            pending_d = match_mask;
            state_d   = (|match_mask) ? ST_SCAN : ST_EMPTY;
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            pending_d = pending_q & ~clr_mask;
            if (single_left) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_EMPTY: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  // State and pending-mask registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Outputs come only from registered state, never from data_in.
  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_SCAN) || (state_q == ST_EMPTY);
  assign none_found  = (state_q == ST_EMPTY);
  assign encoded_out = (state_q == ST_SCAN) ? cur_idx : '0;
  assign out_last    = ((state_q == ST_SCAN) && single_left) || (state_q == ST_EMPTY);
  assign state_dbg   = state_q;

`ifdef SCAN_ENC_MATCH_COUNT_EN
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  logic [CNT_W-1:0] count_q, count_d, mask_pop;

  // Popcount of the incoming match mask.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      mask_pop = mask_pop + CNT_W'(match_mask[i]);
    end
  end

  // Count is loaded on accept, held otherwise, cleared by flush.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if ((state_q == ST_IDLE) && in_valid) begin
      count_d = mask_pop;
    end
  end

  // Match-count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder: directed bench for priority_scan_encoder.
// Instance a: W=8, VAL=0, LSB-first (main scenarios).
// Instance b: W=8, VAL=0, MSB-first. Instance c: W=8, VAL=1, LSB-first.
// Expected beats are {none_found, out_last, encoded_out}.
module tb_priority_scan_encoder;

  logic clk;
  logic rst_n;

  // Instance a signals
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_data;
  logic [2:0] a_encoded_out;
  logic       a_out_last, a_none_found, a_busy;
  logic [1:0] a_state_dbg;
`ifdef SCAN_ENC_MATCH_COUNT_EN
  logic [3:0] a_match_count;
`endif

  // Instance b signals
  logic       b_in_valid, b_in_ready, b_out_valid;
  logic [7:0] b_data;
  logic [2:0] b_encoded_out;
  logic       b_out_last, b_none_found, b_busy;
  logic [1:0] b_state_dbg;
`ifdef SCAN_ENC_MATCH_COUNT_EN
  logic [3:0] b_match_count;
`endif

  // Instance c signals
  logic       c_in_valid, c_in_ready, c_out_valid;
  logic [7:0] c_data;
  logic [2:0] c_encoded_out;
  logic       c_out_last, c_none_found, c_busy;
  logic [1:0] c_state_dbg;
`ifdef SCAN_ENC_MATCH_COUNT_EN
  logic [3:0] c_match_count;
`endif

  logic zero_sig;
  logic one_sig;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [4:0] exp_c[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  priority_scan_encoder #(.INPUT_WIDTH(8), .ENCODED_VAL(0), .MSB_FIRST(0)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (a_flush),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .data_in     (a_data),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .encoded_out (a_encoded_out),
    .out_last    (a_out_last),
    .none_found  (a_none_found),
    .busy        (a_busy),
`ifdef SCAN_ENC_MATCH_COUNT_EN
    .match_count (a_match_count),
`endif
    .state_dbg   (a_state_dbg)
  );

  priority_scan_encoder #(.INPUT_WIDTH(8), .ENCODED_VAL(0), .MSB_FIRST(1)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (zero_sig),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .data_in     (b_data),
    .out_valid   (b_out_valid),
    .out_ready   (one_sig),
    .encoded_out (b_encoded_out),
    .out_last    (b_out_last),
    .none_found  (b_none_found),
    .busy        (b_busy),
`ifdef SCAN_ENC_MATCH_COUNT_EN
    .match_count (b_match_count),
`endif
    .state_dbg   (b_state_dbg)
  );

  priority_scan_encoder #(.INPUT_WIDTH(8), .ENCODED_VAL(1), .MSB_FIRST(0)) u_dut_c (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (zero_sig),
    .in_valid    (c_in_valid),
    .in_ready    (c_in_ready),
    .data_in     (c_data),
    .out_valid   (c_out_valid),
    .out_ready   (one_sig),
    .encoded_out (c_encoded_out),
    .out_last    (c_out_last),
    .none_found  (c_none_found),
    .busy        (c_busy),
`ifdef SCAN_ENC_MATCH_COUNT_EN
    .match_count (c_match_count),
`endif
    .state_dbg   (c_state_dbg)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  task automatic push(input int sel, input logic none, input logic last, input logic [2:0] idx);
    case (sel)
      0:       exp_a.push_back({none, last, idx});
      1:       exp_b.push_back({none, last, idx});
      default: exp_c.push_back({none, last, idx});
    endcase
  endtask

  // Compare a presented beat against the queue head; pop it on handshake.
  task automatic beat_check(input int sel, input logic [4:0] act, input logic ready);
    logic [4:0] exp;
    n_checks++;
    if (qsize(sel) == 0) begin
      n_errors++;
      $display("FAIL beat_%0d: got unexpected beat %0h expected no beat", sel, act);
    end else begin
      case (sel)
        0:       exp = exp_a[0];
        1:       exp = exp_b[0];
        default: exp = exp_c[0];
      endcase
      if (act !== exp) begin
        n_errors++;
        $display("FAIL beat_%0d: got %0h expected %0h", sel, act, exp);
      end
      if (ready) begin
        case (sel)
          0:       void'(exp_a.pop_front());
          1:       void'(exp_b.pop_front());
          default: void'(exp_c.pop_front());
        endcase
      end
    end
  endtask

  // Present one vector for exactly one accepting edge (caller ensures IDLE).
  task automatic send(input int sel, input logic [7:0] v);
    @(posedge clk);
    #1;
    case (sel)
      0:       begin a_in_valid = 1'b1; a_data = v; end
      1:       begin b_in_valid = 1'b1; b_data = v; end
      default: begin c_in_valid = 1'b1; c_data = v; end
    endcase
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
  endtask

  // Wait (bounded) until all expected beats of an instance were consumed.
  task automatic drain(input int sel);
    int n;
    n = 0;
    while (qsize(sel) != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(sel) != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_%0d: got %0d beats outstanding expected 0", sel, qsize(sel));
    end
  endtask

  // ---------------- monitors (scoreboard) ----------------
  always @(negedge clk) begin
    if (rst_n && !a_flush && a_out_valid)
      beat_check(0, {a_none_found, a_out_last, a_encoded_out}, a_out_ready);
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid)
      beat_check(1, {b_none_found, b_out_last, b_encoded_out}, 1'b1);
  end

  always @(negedge clk) begin
    if (rst_n && c_out_valid)
      beat_check(2, {c_none_found, c_out_last, c_encoded_out}, 1'b1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    zero_sig    = 1'b0;
    one_sig     = 1'b1;
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_data      = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_data      = '0;
    c_in_valid  = 1'b0;
    c_data      = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_encoded", a_encoded_out, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_none_found", a_none_found, 0);
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_state", a_state_dbg, 0);

    // LSB-first, VAL=0: 1110_0101 -> 1, 3, 4(last)
    push(0, 0, 0, 3'd1);
    push(0, 0, 0, 3'd3);
    push(0, 0, 1, 3'd4);
    send(0, 8'b1110_0101);
    @(negedge clk);
    check("lat_out_valid", a_out_valid, 1);
    check("lat_in_ready", a_in_ready, 0);
    check("lat_busy", a_busy, 1);
`ifdef SCAN_ENC_MATCH_COUNT_EN
    check("match_count_accept", a_match_count, 3);
`endif
    drain(0);
    @(negedge clk);
    check("post_last_busy", a_busy, 0);
    check("post_last_in_ready", a_in_ready, 1);
    check("post_last_out_valid", a_out_valid, 0);

    // All non-matching: single EMPTY beat
    push(0, 1, 1, 3'd0);
    send(0, 8'hFF);
    drain(0);
    @(negedge clk);
    check("empty_then_in_ready", a_in_ready, 1);
    check("empty_then_none", a_none_found, 0);

    // Backpressure on the first beat for 5 cycles
    a_out_ready = 1'b0;
    push(0, 0, 0, 3'd1);
    push(0, 0, 0, 3'd3);
    push(0, 0, 1, 3'd4);
    send(0, 8'b1110_0101);
    repeat (5) @(negedge clk);
    check("bp_hold_valid", a_out_valid, 1);
    check("bp_hold_idx", a_encoded_out, 1);
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    drain(0);

    // Flush after the first beat
    push(0, 0, 0, 3'd1);
    send(0, 8'b1110_0101);
    @(posedge clk);
    #1 a_flush = 1'b1;
    @(posedge clk);
    #1 a_flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", a_out_valid, 0);
    check("flush_in_ready", a_in_ready, 1);
`ifdef SCAN_ENC_MATCH_COUNT_EN
    check("match_count_flush", a_match_count, 0);
`endif
    check("flush_queue", qsize(0), 0);
    push(0, 0, 1, 3'd0);
    send(0, 8'hFE);
    drain(0);

    // Reset after the first beat
    push(0, 0, 0, 3'd1);
    send(0, 8'b1110_0101);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", a_out_valid, 0);
    check("rstmid_in_ready", a_in_ready, 1);
    check("rstmid_queue", qsize(0), 0);
    push(0, 0, 1, 3'd0);
    send(0, 8'hFE);
    drain(0);

    // MSB-first, VAL=0: 4, 3, 1(last)
    push(1, 0, 0, 3'd4);
    push(1, 0, 0, 3'd3);
    push(1, 0, 1, 3'd1);
    send(1, 8'b1110_0101);
    drain(1);

    // LSB-first, VAL=1: 0, 2, 5, 6, 7(last)
    push(2, 0, 0, 3'd0);
    push(2, 0, 0, 3'd2);
    push(2, 0, 0, 3'd5);
    push(2, 0, 0, 3'd6);
    push(2, 0, 1, 3'd7);
    send(2, 8'b1110_0101);
    drain(2);

    @(negedge clk);
    check("end_b_idle", b_busy, 0);
    check("end_c_idle", c_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_scan_encoder.md
# priority_scan_encoder

Sequential, parametrised successor to the BISR combinational priority encoder. It captures one fault/status vector and streams out, one per handshake, the index of every bit equal to `ENCODED_VAL`, in LSB-first or MSB-first order. It sits between the fault-map registers and the weight-proxy spare allocator, so every faulty PE is reported instead of only one.

## Interface
- `INPUT_WIDTH`, 16: vector width, ≥1.
- `ENCODED_VAL`, 0: bit value that counts as a match (0 or 1).
- `MSB_FIRST`, 0: 0 = lowest index first, 1 = highest index first.
- `IDX_W` (localparam): max(1, $clog2(INPUT_WIDTH)).
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous abort; returns to IDLE.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  block accepts a vector (IDLE only).
- `data_in`  in  INPUT_WIDTH  vector to scan.
- `out_valid`  out  1  `encoded_out` / flags valid.
- `out_ready`  in  1  consumer takes the current index.
- `encoded_out`  out  IDX_W  index of the current match.
- `out_last`  out  1  current beat is the final one for this vector.
- `none_found`  out  1  vector had no match (single beat, `encoded_out`=0).
- `busy`  out  1  not IDLE.

## Operation
- States: IDLE, SCAN, EMPTY.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `pending <= ENCODED_VAL ? data_in : ~data_in`. Go to SCAN if the mask is nonzero, else EMPTY.
- SCAN: `out_valid`=1. `encoded_out` = first set bit of `pending` in the configured order. `out_last`=1 iff exactly one bit of `pending` is set.
  - On `out_valid && out_ready`: clear that bit in `pending`.
  - If `out_last`, go to IDLE.
- EMPTY: `out_valid`=1, `none_found`=1, `out_last`=1, `encoded_out`=0. On `out_ready`, go to IDLE.
- Outputs derive only from the registered `state`/`pending`; there is no combinational path from `data_in` to the outputs.
- While `out_valid`=1 and `out_ready`=0, `encoded_out`, `out_last` and `none_found` stay stable.
- Priority: `rst_n` low > `flush` > handshakes.
  - `flush` in any state: `pending` <= 0, state <= IDLE, no beat consumed.
  - `flush` coincident with `in_valid` in IDLE: the vector is not accepted.
- `in_valid` outside IDLE is ignored; `in_ready`=0 there.

## Timing
- Reset (rst_n low at an edge): state IDLE, `pending`=0.
- Output values at and after reset: `out_valid`=0, `encoded_out`=0, `out_last`=0, `none_found`=0, `busy`=0. `in_ready`=1 from the first cycle after reset.
- Latency: vector accepted at edge N gives `out_valid`=1 in cycle N+1.
- Throughput: one index per cycle with `out_ready` held high. A vector with k matches occupies k+1 cycles (k ≥ 1); a no-match vector occupies 2 cycles.
- After the last beat the block is back in IDLE the next cycle. There is one bubble cycle before the next accept.
- Reset or flush mid-scan: remaining indices are discarded and `out_valid` drops the following cycle.
- Any `data_in` that is all-non-matching takes the EMPTY path, including the `INPUT_WIDTH`=1 case.

## Configuration
- `SCAN_ENC_MATCH_COUNT_EN` defined:
  - Adds output `match_count` [$clog2(INPUT_WIDTH+1)-1:0], set at accept to the popcount of the match mask.
  - Held until the next accept; reset and `flush` clear it to 0.
- Undefined: no port, no popcount logic; all other behaviour is identical.

## Structure
- Package `scan_enc_pkg`: state enum typedef (IDLE, SCAN, EMPTY) and the `IDX_W` computation function.
- Sub-module `first_one_finder`: combinational LSB-first index and one-hot output, parametrised on width.
  - MSB_FIRST is built by bit-reversing the input and index around it.
  - `pending` update is `pending & ~onehot`.

## Test plan
- W=8, VAL=0, MSB_FIRST=0, `data_in`=8'b1110_0101, `out_ready`=1 -> beats 1, 3, 4; `out_last` only on 4; IDLE on the next cycle.
- Same vector with MSB_FIRST=1 -> beats 4, 3, 1. With VAL=1 and LSB-first -> beats 0, 2, 5, 6, 7.
- `data_in`=8'hFF, VAL=0 -> exactly one beat: `none_found`=1, `out_last`=1, `encoded_out`=0. Then `in_ready`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles during the first beat -> `encoded_out`=1 is stable throughout and no index is skipped.
- Flush and reset mid-scan:
  - `flush` after the first beat -> `out_valid`=0 the next cycle. A new vector 8'hFE (VAL=0) then gives the single beat 0.
  - Repeat with `rst_n` low instead of `flush` -> same response.
- Count macro: with `SCAN_ENC_MATCH_COUNT_EN` defined, vector 8'b1110_0101 (VAL=0) -> `match_count`=3. After `flush` -> 0.
